nibble_serial_adder_ctrl: RTL and testbench

Multi-precision add/subtract sequencer built around our 4-bit full-adder slice. It accepts WIDTH-bit two's-complement operands and processes one nibble per clock, least significant nibble first, through a single 4-bit ripple slice. A registered carry links the nibbles, so a narrow datapath produces a wide sum. A start/ready/done handshake lets an upstream controller issue operations and collect the result, carryout and signed overflow.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 25 ++
 rtl/nibble_serial_adder_ctrl.sv | 95 +++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Start/ready/done handshake bundle for the nibble-serial add/sub sequencer.
// Ports: start, sub, a, b (upstream to sequencer); ready, done, result, carryout, overflow (back).
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  ready, done, result, carryout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, result, carryout, overflow
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/sub: one 4-bit ripple slice, one nibble per clock, LSB first.
// Ports: clk, reset (sync, active-high), bus (slave side of nibble_serial_adder_ctrl_if).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                       clk,
    input logic                       reset,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int SW  = $clog2(NIB);
    localparam logic [SW-1:0] LAST = SW'(NIB - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [SW-1:0]    step;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             ovf;

    logic [3:0]       an;
    logic [3:0]       bn;
    logic [3:0]       sum;
    logic             c3;
    logic             c4;

    // 4-bit ripple slice; c3 is the carry into the slice MSB, used for
    // signed overflow on the final nibble.
    always_comb begin
        logic cy;
        an  = a_reg[{step, 2'b00} +: 4];
        bn  = b_reg[{step, 2'b00} +: 4];
        sum = '0;
        c3  = 1'b0;
        cy  = carry;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) c3 = cy;
            sum[i] = an[i] ^ bn[i] ^ cy;
            cy     = (an[i] & bn[i]) | (cy & (an[i] ^ bn[i]));
        end
        c4 = cy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            step  <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            res   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        // subtract as a + ~b + 1, the +1 riding in on carry
                        a_reg <= bus.a;
                        b_reg <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub;
                        step  <= '0;
                        res   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res[{step, 2'b00} +: 4] <= sum;
                    carry <= c4;
                    if (step == LAST) begin
                        cout  <= c4;
                        ovf   <= c3 ^ c4;
                        state <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.done     = (state == DONE);
    assign bus.result   = res;
    assign bus.carryout = cout;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16).
// Ports: none; drives the handshake interface and checks against hand values / word model.
module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] a_t [20] = '{
        16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h1234,
        16'hABCD, 16'h0F0F, 16'h8000, 16'h0001, 16'hFFFE,
        16'h5A5A, 16'h7FFF, 16'h8001, 16'h0000, 16'hC3C3,
        16'h3333, 16'hFFFF, 16'h4000, 16'h9999, 16'h0808
    };
    logic [15:0] b_t [20] = '{
        16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 16'hEDCC,
        16'h1111, 16'hF0F1, 16'h0001, 16'h0002, 16'h7FFF,
        16'hA5A5, 16'hFFFF, 16'h0002, 16'h0000, 16'h3C3D,
        16'h4444, 16'h0001, 16'h4000, 16'h6667, 16'h0808
    };
    logic        s_t [20] = '{
        1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b1, 1'b1
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // whole-word reference: {overflow, carryout, result}
    function automatic logic [17:0] ref_op(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic s);
        logic [15:0] bb;
        logic [16:0] w;
        logic        v;
        bb = s ? ~b : b;
        w  = {1'b0, a} + {1'b0, bb} + {16'd0, s};
        v  = (a[15] == bb[15]) && (w[15] != a[15]);
        return {v, w[16], w[15:0]};
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s, output int at);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        at        = cyc;
        bus.start = 1'b0;
    endtask

    // lat = number of edges from the start edge to the edge that samples done
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i + 1;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] r,
                             input logic c, input logic v);
        chk({tag, "_res"}, {16'd0, bus.result}, {16'd0, r});
        chk({tag, "_cout"}, {31'd0, bus.carryout}, {31'd0, c});
        chk({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, v});
    endtask

    task automatic op(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input logic s,
                      input logic [15:0] r, input logic c,
                      input logic v, output int at);
        int lat;
        issue(a, b, s, at);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 5);
        check_res(tag, r, c, v);
        @(posedge clk);
        #1;
        chk({tag, "_rdy"}, {31'd0, bus.ready}, 32'd1);
        chk({tag, "_done1"}, {31'd0, bus.done}, 32'd0);
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        int          prev;
        int          lat;
        int          cnt;
        logic [17:0] m;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        check_res("rst", 16'h0000, 1'b0, 1'b0);

        op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, t);
        op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, t);
        op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, t);
        op("sub1", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, t);
        op("sub2", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, t);

        // start during RUN must be ignored
        issue(16'h00FF, 16'h0001, 1'b0, t);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("ign_busy", {31'd0, bus.ready}, 32'd0);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.sub   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        check_res("ign", 16'h0100, 1'b0, 1'b0);
        count_done(12, cnt);
        chk("ign_one_done", cnt, 0);
        chk("ign_hold", {16'd0, bus.result}, 32'h0100);

        // reset in the third RUN cycle aborts
        issue(16'hFFFF, 16'hFFFF, 1'b0, t);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_part", {16'd0, bus.result}, 32'h00FE);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        check_res("abort", 16'h0000, 1'b0, 1'b0);
        count_done(10, cnt);
        chk("abort_nodone", cnt, 0);
        op("fresh", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, t);

        // back-to-back issue on the first ready cycle after each done
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            m = ref_op(a_t[i], b_t[i], s_t[i]);
            op($sformatf("b2b%0d", i), a_t[i], b_t[i], s_t[i],
               m[15:0], m[16], m[17], t);
            if (i > 0) chk($sformatf("b2b%0d_ii", i), t - prev, 6);
            prev = t;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
